// File: rtl/id_stage_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : id_stage_sb_pkg
// Description : Shared types, opcodes and the forwarding priority mux for the
//               scoreboarded decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
package id_stage_sb_pkg;

  // Internal datapath width for the forwarding network; XLEN must not exceed it.
  localparam int DATA_W   = 64;
  // Forwarding network is sized to this maximum; unused sources are tied off.
  localparam int MAX_FWD  = 8;
  localparam int SB_CNT_W = 4;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_OP32    = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        wb_en;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jump;
    logic        is_csr;
    logic        is_word;
    logic        alu_src_imm;
    logic        alu_src_pc;
    alu_op_e     alu_op;
    logic [2:0]  funct3;
    logic [31:0] imm;
  } id_ctrl_t;

  typedef struct packed {
    logic                valid;
    logic [4:0]          rd;
    logic [SB_CNT_W-1:0] cnt;
  } sb_entry_t;

  typedef struct packed {
    logic              valid;
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
  } fwd_src_t;

  // Map funct3 plus the alternate bit (instr[30]) onto an ALU operation.
  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Operand priority mux: x0 reads zero, otherwise the lowest-index matching
  // source wins, otherwise the fallback value (register file or held operand).
  function automatic logic [DATA_W-1:0] fwd_select(
    input logic [4:0]                 idx,
    input logic [DATA_W-1:0]          fallback,
    input fwd_src_t [MAX_FWD-1:0]     src
  );
    logic [DATA_W-1:0] res;
    logic              hit;
    res = fallback;
    hit = 1'b0;
    if (idx == 5'd0) begin
      res = '0;
    end else begin
      for (int i = 0; i < MAX_FWD; i++) begin
        if (!hit && src[i].valid && (src[i].rd == idx)) begin
          res = src[i].data;
          hit = 1'b1;
        end
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_stage_sb_load_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : load_scoreboard
// Description : Tracks in-flight loads until their data becomes forwardable.
// Revision    : 1.0 - initial release
// ============================================================================
module load_scoreboard
  import id_stage_sb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int LAT   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_ins_valid,
  input  logic [4:0] i_ins_rd,
  input  logic [4:0] i_lk1_rd,
  output logic       o_lk1_hit,
  input  logic [4:0] i_lk2_rd,
  output logic       o_lk2_hit
);

  sb_entry_t [DEPTH-1:0] r_sb;
  logic      [DEPTH-1:0] w_ins_sel;

  // Pick the lowest entry that is empty or expiring this cycle for a new load.
  always_comb begin : p_pick
    logic found;
    found     = 1'b0;
    w_ins_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && (!r_sb[i].valid || (r_sb[i].cnt == SB_CNT_W'(1)))) begin
        w_ins_sel[i] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  // Lookups ignore entries at cnt==1: that load's value is already on a
  // forwarding source, so the consumer may proceed.
  always_comb begin
    o_lk1_hit = 1'b0;
    o_lk2_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_sb[i].valid && (r_sb[i].cnt > SB_CNT_W'(1))) begin
        if (r_sb[i].rd == i_lk1_rd) o_lk1_hit = 1'b1;
        if (r_sb[i].rd == i_lk2_rd) o_lk2_hit = 1'b1;
      end
    end
  end

  // Insert new loads and count down the live entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sb <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_ins_valid && w_ins_sel[i]) begin
          r_sb[i] <= '{valid: 1'b1, rd: i_ins_rd, cnt: SB_CNT_W'(LAT)};
        end else if (r_sb[i].valid) begin
          if (r_sb[i].cnt == SB_CNT_W'(1)) r_sb[i].valid <= 1'b0;
          else                             r_sb[i].cnt   <= r_sb[i].cnt - SB_CNT_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/id_stage_sb_main_decoder.sv
`default_nettype none
// ============================================================================
// Module      : main_decoder
// Description : Combinational RV64I main decoder producing id_ctrl_t.
// Revision    : 1.0 - initial release
// ============================================================================
module main_decoder
  import id_stage_sb_pkg::*;
(
  input  logic [31:0] i_instr,
  output id_ctrl_t    o_ctrl
);

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;

  assign w_opc   = i_instr[6:0];
  assign w_f3    = i_instr[14:12];
  assign w_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_u = {i_instr[31:12], 12'b0};
  assign w_imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

  // Decode the opcode into register usage, writeback and execute controls.
  always_comb begin
    o_ctrl        = '0;
    o_ctrl.rs1    = i_instr[19:15];
    o_ctrl.rs2    = i_instr[24:20];
    o_ctrl.funct3 = w_f3;
    o_ctrl.alu_op = ALU_ADD;
    case (w_opc)
      OPC_LUI: begin
        o_ctrl.wb_en = 1'b1; o_ctrl.alu_src_imm = 1'b1;
        o_ctrl.alu_op = ALU_PASSB; o_ctrl.imm = w_imm_u;
      end
      OPC_AUIPC: begin
        o_ctrl.wb_en = 1'b1; o_ctrl.alu_src_imm = 1'b1;
        o_ctrl.alu_src_pc = 1'b1; o_ctrl.imm = w_imm_u;
      end
      OPC_JAL: begin
        o_ctrl.wb_en = 1'b1; o_ctrl.is_jump = 1'b1;
        o_ctrl.alu_src_pc = 1'b1; o_ctrl.imm = w_imm_j;
      end
      OPC_JALR: begin
        o_ctrl.wb_en = 1'b1; o_ctrl.is_jump = 1'b1; o_ctrl.uses_rs1 = 1'b1;
        o_ctrl.alu_src_imm = 1'b1; o_ctrl.imm = w_imm_i;
      end
      OPC_BRANCH: begin
        o_ctrl.uses_rs1 = 1'b1; o_ctrl.uses_rs2 = 1'b1; o_ctrl.is_branch = 1'b1;
        o_ctrl.alu_op = ALU_SUB; o_ctrl.imm = w_imm_b;
      end
      OPC_LOAD: begin
        o_ctrl.wb_en = 1'b1; o_ctrl.is_load = 1'b1; o_ctrl.uses_rs1 = 1'b1;
        o_ctrl.alu_src_imm = 1'b1; o_ctrl.imm = w_imm_i;
      end
      OPC_STORE: begin
        o_ctrl.uses_rs1 = 1'b1; o_ctrl.uses_rs2 = 1'b1; o_ctrl.is_store = 1'b1;
        o_ctrl.alu_src_imm = 1'b1; o_ctrl.imm = w_imm_s;
      end
      OPC_OPIMM, OPC_OPIMM32: begin
        o_ctrl.wb_en = 1'b1; o_ctrl.uses_rs1 = 1'b1; o_ctrl.alu_src_imm = 1'b1;
        o_ctrl.is_word = (w_opc == OPC_OPIMM32);
        o_ctrl.alu_op = alu_decode(w_f3, (w_f3 == 3'b101) & i_instr[30]);
        o_ctrl.imm = w_imm_i;
      end
      OPC_OP, OPC_OP32: begin
        o_ctrl.wb_en = 1'b1; o_ctrl.uses_rs1 = 1'b1; o_ctrl.uses_rs2 = 1'b1;
        o_ctrl.is_word = (w_opc == OPC_OP32);
        o_ctrl.alu_op = alu_decode(w_f3, i_instr[30]);
      end
      OPC_SYSTEM: begin
        o_ctrl.is_csr   = (w_f3 != 3'b000);
        o_ctrl.wb_en    = (w_f3 != 3'b000);
        o_ctrl.uses_rs1 = (w_f3 != 3'b000) & ~w_f3[2];
        o_ctrl.imm      = {27'b0, i_instr[19:15]};
      end
      default: ;
    endcase
    // rd is only meaningful when the instruction writes back.
    o_ctrl.rd = o_ctrl.wb_en ? i_instr[11:7] : 5'd0;
  end

endmodule
`default_nettype wire

// File: rtl/id_stage_sb.sv
`default_nettype none
// ============================================================================
// Module      : id_stage_sb
// Description : Decode stage with ready/valid on both sides, N-source operand
//               forwarding and load-scoreboard hazard detection.
// Revision    : 1.0 - initial release
// ============================================================================
module id_stage_sb
  import id_stage_sb_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int NFWD     = 3,
  parameter int LOAD_LAT = 2,
  parameter int SB_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [63:0]          in_pc,
  input  logic [31:0]          in_instr,
  output logic [4:0]           rf_rs1_idx,
  output logic [4:0]           rf_rs2_idx,
  input  logic [XLEN-1:0]      rf_rs1_data,
  input  logic [XLEN-1:0]      rf_rs2_data,
  input  logic [NFWD-1:0]      fwd_valid,
  input  logic [NFWD*5-1:0]    fwd_rd,
  input  logic [NFWD*XLEN-1:0] fwd_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          out_pc,
  output logic [31:0]          out_instr,
  output logic [XLEN-1:0]      out_rs1_val,
  output logic [XLEN-1:0]      out_rs2_val,
  output id_ctrl_t             out_ctrl
);

  if (SB_DEPTH < LOAD_LAT) begin : g_bad_sb_depth
    $error("id_stage_sb: SB_DEPTH must be >= LOAD_LAT");
  end
  if ((NFWD > MAX_FWD) || (XLEN > DATA_W)) begin : g_bad_size
    $error("id_stage_sb: NFWD or XLEN exceeds package limits");
  end

  id_ctrl_t                 w_dec;
  fwd_src_t [MAX_FWD-1:0]   w_fwd;
  logic [DATA_W-1:0]        w_cap_rs1, w_cap_rs2, w_hold_rs1, w_hold_rs2;
  logic                     w_sb_hit1, w_sb_hit2, w_haz1, w_haz2, w_hazard;
  logic                     w_capture, w_issue_load;

  logic                     r_valid;
  logic [63:0]              r_pc;
  logic [31:0]              r_instr;
  id_ctrl_t                 r_ctrl;
  logic [XLEN-1:0]          r_rs1, r_rs2;

  main_decoder u_dec (
    .i_instr (in_instr),
    .o_ctrl  (w_dec)
  );

  // Pack the flat forwarding buses into structs; unused slots never match.
  for (genvar g = 0; g < MAX_FWD; g++) begin : g_fwd
    if (g < NFWD) begin : g_src
      assign w_fwd[g] = {fwd_valid[g], fwd_rd[g*5 +: 5], DATA_W'(fwd_data[g*XLEN +: XLEN])};
    end else begin : g_none
      assign w_fwd[g] = '0;
    end
  end

  assign rf_rs1_idx = w_dec.rs1;
  assign rf_rs2_idx = w_dec.rs2;

  assign w_cap_rs1  = fwd_select(w_dec.rs1, DATA_W'(rf_rs1_data), w_fwd);
  assign w_cap_rs2  = fwd_select(w_dec.rs2, DATA_W'(rf_rs2_data), w_fwd);
  assign w_hold_rs1 = fwd_select(r_ctrl.rs1, DATA_W'(r_rs1), w_fwd);
  assign w_hold_rs2 = fwd_select(r_ctrl.rs2, DATA_W'(r_rs2), w_fwd);

  // A load still sitting in the output register has not reached the
  // scoreboard yet, so it is checked separately.
  assign w_haz1 = w_dec.uses_rs1 & (w_dec.rs1 != 5'd0) &
                  (w_sb_hit1 | (r_valid & r_ctrl.is_load & (r_ctrl.rd == w_dec.rs1)));
  assign w_haz2 = w_dec.uses_rs2 & (w_dec.rs2 != 5'd0) &
                  (w_sb_hit2 | (r_valid & r_ctrl.is_load & (r_ctrl.rd == w_dec.rs2)));
  assign w_hazard = in_valid & (w_haz1 | w_haz2);

  assign in_ready     = ~w_hazard & ~flush & (~r_valid | out_ready);
  assign w_capture    = in_valid & in_ready;
  assign w_issue_load = r_valid & out_ready & r_ctrl.is_load & (r_ctrl.rd != 5'd0) & ~flush;

  load_scoreboard #(
    .DEPTH (SB_DEPTH),
    .LAT   (LOAD_LAT)
  ) u_sb (
    .clk         (clk),
    .rst         (rst),
    .i_ins_valid (w_issue_load),
    .i_ins_rd    (r_ctrl.rd),
    .i_lk1_rd    (w_dec.rs1),
    .o_lk1_hit   (w_sb_hit1),
    .i_lk2_rd    (w_dec.rs2),
    .o_lk2_hit   (w_sb_hit2)
  );

  // Output register: capture, drain, or hold while refreshing operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
      r_ctrl  <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid <= 1'b1;
      r_pc    <= in_pc;
      r_instr <= in_instr;
      r_ctrl  <= w_dec;
      r_rs1   <= w_cap_rs1[XLEN-1:0];
      r_rs2   <= w_cap_rs2[XLEN-1:0];
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end else if (r_valid) begin
      r_rs1   <= w_hold_rs1[XLEN-1:0];
      r_rs2   <= w_hold_rs2[XLEN-1:0];
    end
  end

  assign out_valid   = r_valid;
  assign out_pc      = r_pc;
  assign out_instr   = r_instr;
  assign out_ctrl    = r_ctrl;
  assign out_rs1_val = r_rs1;
  assign out_rs2_val = r_rs2;

endmodule
`default_nettype wire
